wb_readback_uart: RTL
=====================

// Module: wb_readback_uart
// PURPOSE
//  Downstream stage of the Wishbone bus master. It captures every acknowledged read
//  (stb_i & ack_i & !we_i) from the multiplexed slave data into a small FIFO.
//  It then serialises the captured bytes as UART 8N1 frames on the LPC RX line.
//  Decouples bus read bursts from the slow serial return path; reports overflow.
// PARAMETERS
//  CLKS_PER_BIT     16  clk_i cycles per UART bit; legal range >= 2
//  FIFO_AW          4   FIFO address width; depth = 2**FIFO_AW (16)
// PORTS
//  clk_i       in   1  system clock; the only clock
//  rst_i       in   1  synchronous, active-high reset
//  stb_i       in   1  bus master strobe
//  we_i        in   1  bus write enable; 1 = write cycle, never captured
//  ack_i       in   1  muxed slave acknowledge
//  dat_i       in   8  muxed slave read data
//  clr_ovf     in   1  one-cycle pulse; clears overflow
//  dout        out  1  UART TX line; idle high
//  fifo_empty  out  1  FIFO holds 0 entries
//  fifo_full   out  1  FIFO holds 2**FIFO_AW entries
//  overflow    out  1  sticky; a capture was dropped because the FIFO was full
//  busy        out  1  TX FSM not in IDLE
// BEHAVIOUR
//  Reset: dout=1, fifo_empty=1, fifo_full=0, overflow=0, busy=0, FSM=IDLE.
//   Pointers and count are cleared. FIFO contents are discarded.
//  Reset mid-frame: the frame is aborted. dout=1 from the cycle after rst_i is sampled.
//  Capture: push dat_i on every cycle where stb_i & ack_i & !we_i.
//   One push per qualifying cycle. Write cycles are ignored.
//  Full: a push while full and with no pop that cycle is dropped, and overflow<=1.
//  Push and pop in the same cycle: both take effect and count is unchanged.
//   This also applies when the FIFO is full.
//  Pointers are FIFO_AW bits and wrap modulo depth. count is FIFO_AW+1 bits.
//   Status flags are derived from registered count and valid the cycle after an update.
//  Overflow: if the set condition and clr_ovf occur in the same cycle, set wins.
//  TX FSM; all states registered; bit counter 3b; baud counter $clog2(CLKS_PER_BIT)b:
//   IDLE : dout=1. If !fifo_empty, pop the head into an 8b shift register,
//          clear the baud counter, and go to START.
//   START: dout=0 for CLKS_PER_BIT cycles, then go to DATA with bit counter=0.
//   DATA : dout=shift[0] (LSB first) for CLKS_PER_BIT cycles per bit.
//          After each bit, shift right. After bit 7, go to STOP.
//   STOP : dout=1 for CLKS_PER_BIT cycles, then go to IDLE.
//          IDLE always lasts at least 1 cycle.
//  dout is driven from a flop.
//  Latency: a push in cycle N gives fifo_empty=0 in N+1, a pop in N+1, START in N+2,
//   and dout=0 first visible in N+3.
//  Frame period for back-to-back bytes is 10*CLKS_PER_BIT+1 cycles.
//  busy=1 in START, DATA and STOP.
// TESTING (CLKS_PER_BIT=4, FIFO_AW=4)
//  1. Single read ack with dat_i=8'hA5.
//     -> dout: 4 cycles 0, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 4 cycles 1.
//     -> busy high for exactly 40 cycles.
//  2. Ack with we_i=1 and dat_i=8'h3C -> no push; fifo_empty stays 1; dout stays 1.
//  3. 18 consecutive read acks, bytes 0..17.
//     -> byte 0 is popped at cycle 1; the FIFO reaches full at cycle 16.
//     -> byte 17 is dropped and overflow=1.
//     -> bytes 0..16 are transmitted in order, each frame spaced 41 cycles.
//  4. overflow=1 with clr_ovf pulsed alone -> overflow=0 the next cycle.
//     clr_ovf in the same cycle as a dropped push -> overflow stays 1.
//  5. rst_i asserted during DATA bit 3 of 8'hFF with 3 bytes queued.
//     -> dout=1, busy=0 and fifo_empty=1 the next cycle.
//     -> no further frames are sent after rst_i is released.
//  6. Pointer wrap: 40 reads spaced 45 cycles apart.
//     -> all 40 bytes are received intact; overflow stays 0.

Source files
------------

// File: rtl/wb_readback_uart.sv
`default_nettype none
// ============================================================================
// Module  : wb_readback_uart
// Brief   : Captures acknowledged Wishbone read data into a FIFO and returns
//           it as UART 8N1 frames on a single TX line; flags dropped captures.
// Rev     : 1.0  initial release
// ============================================================================
module wb_readback_uart #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_AW      = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic       ack_i,
    input  logic [7:0] dat_i,
    input  logic       clr_ovf,
    output logic       dout,
    output logic       fifo_empty,
    output logic       fifo_full,
    output logic       overflow,
    output logic       busy
);

    localparam int                 c_baud_w     = $clog2(CLKS_PER_BIT);
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   c_count_full = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]         r_mem [0:(1 << FIFO_AW) - 1];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_overflow;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_baud_w-1:0] r_baud;
    logic [c_baud_w-1:0] w_baud_nxt;
    logic [2:0]         r_bit;
    logic [2:0]         w_bit_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic               r_dout;
    logic               w_dout_nxt;

    logic               w_push;
    logic               w_pop;
    logic               w_wr_en;
    logic               w_baud_end;

    assign fifo_empty = (r_count == '0);
    assign fifo_full  = (r_count == c_count_full);
    assign overflow   = r_overflow;
    assign busy       = (r_state != S_IDLE);
    assign dout       = r_dout;

    assign w_push     = stb_i & ack_i & ~we_i;
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign w_wr_en    = w_push & (~fifo_full | w_pop);
    assign w_baud_end = (r_baud == c_baud_last);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push & fifo_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_dout  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_dout  <= w_dout_nxt;
        end
    end

    // The line level is registered, so dout trails the state by one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        w_dout_nxt  = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_baud_nxt  = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_dout_nxt = 1'b0;
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            S_DATA: begin
                w_dout_nxt = r_shift[0];
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
